// File: rtl/usart_tx_scheduler.sv
// Transmit scheduler between the UDR holding register and the USART tx frame FSM.
// Holds one pending byte, hands it to the frame FSM, inserts an inter-frame gap and drives the UDRE/TXC flags.
module usart_tx_scheduler #(
  parameter int DATA_W     = 9,
  parameter int GAP_CYCLES = 1,
  parameter int GAP_W      = 4
) (
  input  logic              i_txclk,
  input  logic              i_rst_n,
  input  logic              i_txen,
  input  logic              i_wr_udr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_txc_clr,
  input  logic              i_udrie,
  input  logic              i_txcie,
  input  logic              i_start_bit_insert,
  input  logic              i_transmit_complete,
  output logic              o_data_in_udr,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_udre,
  output logic              o_txc,
  output logic              o_udre_irq,
  output logic              o_txc_irq,
  output logic              o_wr_overrun,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  localparam int               GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_LOAD_I[GAP_W-1:0];

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                udre_q, udre_d;
  logic                txc_q, txc_d;
  logic                data_in_udr_q, data_in_udr_d;
  logic                wr_overrun_q, wr_overrun_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic handoff;
  logic wr_accept;
  logic frame_done;
  logic txc_set;

  // The buffer frees up on the hand-off edge, so a write in that same cycle lands.
  assign handoff    = (state_q == S_REQ) & i_start_bit_insert;
  assign wr_accept  = i_wr_udr & (udre_q | handoff);
  assign frame_done = (state_q == S_BUSY) & i_transmit_complete;
  assign txc_set    = frame_done & udre_q & ~i_wr_udr;

  always_ff @(posedge i_txclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      tx_data_q     <= '0;
      udre_q        <= 1'b1;
      txc_q         <= 1'b0;
      data_in_udr_q <= 1'b0;
      wr_overrun_q  <= 1'b0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      udre_q        <= udre_d;
      txc_q         <= txc_d;
      data_in_udr_q <= data_in_udr_d;
      wr_overrun_q  <= wr_overrun_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_txen && !udre_q) state_d = S_REQ;
      S_REQ: begin
        if (i_start_bit_insert) state_d = S_BUSY;
        else if (!i_txen)       state_d = S_IDLE;
      end
      // Disabling the transmitter never aborts a frame already on the wire.
      S_BUSY: begin
        if (i_transmit_complete) begin
          if (GAP_CYCLES == 0) state_d = S_IDLE;
          else                 state_d = S_GAP;
        end
      end
      S_GAP:   if (gap_cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_in_udr_d = (state_d == S_REQ);
    tx_data_d     = wr_accept ? i_wr_data : tx_data_q;
    wr_overrun_d  = i_wr_udr & ~wr_accept;

    udre_d = udre_q;
    if (wr_accept)    udre_d = 1'b0;
    else if (handoff) udre_d = 1'b1;

    txc_d = txc_set | (txc_q & ~i_txc_clr);

    gap_cnt_d = gap_cnt_q;
    if (frame_done)
      gap_cnt_d = GAP_LOAD;
    else if (state_q == S_GAP && gap_cnt_q != '0)
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
  end

  assign o_data_in_udr = data_in_udr_q;
  assign o_tx_data     = tx_data_q;
  assign o_udre        = udre_q;
  assign o_txc         = txc_q;
  assign o_udre_irq    = udre_q & i_udrie;
  assign o_txc_irq     = txc_q & i_txcie;
  assign o_wr_overrun  = wr_overrun_q;
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_usart_tx_scheduler.sv
// Bench for usart_tx_scheduler: table of single-cycle UDR vectors, a tx frame FSM model,
// and a byte scoreboard checked at every hand-off.
module tb_usart_tx_scheduler;

  localparam int DATA_W = 9;
  localparam int FRAME  = 4;

  logic              i_txclk;
  logic              i_rst_n;
  logic              i_txen;
  logic              i_wr_udr;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_txc_clr;
  logic              i_udrie;
  logic              i_txcie;
  logic              i_start_bit_insert;
  logic              i_transmit_complete;
  logic              o_data_in_udr;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_udre;
  logic              o_txc;
  logic              o_udre_irq;
  logic              o_txc_irq;
  logic              o_wr_overrun;
  logic              o_busy;

  usart_tx_scheduler #(.DATA_W(DATA_W), .GAP_CYCLES(1), .GAP_W(4)) dut (
    .i_txclk             (i_txclk),
    .i_rst_n             (i_rst_n),
    .i_txen              (i_txen),
    .i_wr_udr            (i_wr_udr),
    .i_wr_data           (i_wr_data),
    .i_txc_clr           (i_txc_clr),
    .i_udrie             (i_udrie),
    .i_txcie             (i_txcie),
    .i_start_bit_insert  (i_start_bit_insert),
    .i_transmit_complete (i_transmit_complete),
    .o_data_in_udr       (o_data_in_udr),
    .o_tx_data           (o_tx_data),
    .o_udre              (o_udre),
    .o_txc               (o_txc),
    .o_udre_irq          (o_udre_irq),
    .o_txc_irq           (o_txc_irq),
    .o_wr_overrun        (o_wr_overrun),
    .o_busy              (o_busy)
  );

  initial i_txclk = 1'b0;
  always #5 i_txclk = ~i_txclk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] sb_q[$];

  int m_cnt;
  bit m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_txclk);
    #1;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d, input bit push);
    i_wr_udr  = 1'b1;
    i_wr_data = d;
    if (push) sb_q.push_back(d);
    tick();
    i_wr_udr = 1'b0;
  endtask

  // tx frame FSM model: answers a request one cycle later, then holds complete low for FRAME cycles.
  initial begin
    i_start_bit_insert  = 1'b0;
    i_transmit_complete = 1'b1;
    m_busy = 1'b0;
    m_cnt  = 0;
    forever begin
      @(negedge i_txclk);
      if (!i_rst_n) begin
        i_start_bit_insert  = 1'b0;
        i_transmit_complete = 1'b1;
        m_busy = 1'b0;
        m_cnt  = 0;
      end else if (i_start_bit_insert) begin
        i_start_bit_insert  = 1'b0;
        i_transmit_complete = 1'b0;
        m_busy = 1'b1;
        m_cnt  = FRAME;
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          i_transmit_complete = 1'b1;
          m_busy = 1'b0;
        end
      end else if (o_data_in_udr) begin
        i_start_bit_insert = 1'b1;
        if (sb_q.size() == 0) chk("sb_unexpected_frame", 32'd1, 32'd0);
        else chk("sb_tx_data", o_tx_data, sb_q.pop_front());
      end
    end
  end

  typedef struct {
    logic              wr;
    logic [DATA_W-1:0] dat;
    logic              acc;
    logic              udrie;
    logic              e_udre;
    logic              e_ovr;
    logic              e_uirq;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int req_seen;

    vecs[0] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'h000};
    vecs[1] = '{1'b1, 9'h0A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0A5};
    vecs[2] = '{1'b1, 9'h1FF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0A5};
    vecs[3] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0A5};
    vecs[4] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0A5};

    i_rst_n   = 1'b0;
    i_txen    = 1'b0;
    i_wr_udr  = 1'b0;
    i_wr_data = '0;
    i_txc_clr = 1'b0;
    i_udrie   = 1'b0;
    i_txcie   = 1'b0;
    repeat (3) tick();
    chk("rst_udre", o_udre, 1);
    chk("rst_txc", o_txc, 0);
    chk("rst_req", o_data_in_udr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovr", o_wr_overrun, 0);
    chk("rst_data", o_tx_data, 0);
    i_rst_n = 1'b1;

    // UDR buffer vectors with the transmitter disabled: byte must stay pending.
    foreach (vecs[i]) begin
      i_wr_udr  = vecs[i].wr;
      i_wr_data = vecs[i].dat;
      i_udrie   = vecs[i].udrie;
      if (vecs[i].acc) sb_q.push_back(vecs[i].dat);
      tick();
      chk($sformatf("vec%0d_udre", i), o_udre, vecs[i].e_udre);
      chk($sformatf("vec%0d_ovr", i), o_wr_overrun, vecs[i].e_ovr);
      chk($sformatf("vec%0d_uirq", i), o_udre_irq, vecs[i].e_uirq);
      chk($sformatf("vec%0d_data", i), o_tx_data, vecs[i].e_data);
      chk($sformatf("vec%0d_req", i), o_data_in_udr, 0);
    end
    i_wr_udr = 1'b0;
    i_udrie  = 1'b0;

    // Enable: pending 0x0A5 is requested and sent, TXC sets at frame end.
    i_txen = 1'b1;
    tick();
    chk("en_req", o_data_in_udr, 1);
    chk("en_busy", o_busy, 1);
    tick();
    chk("handoff_req_low", o_data_in_udr, 0);
    chk("handoff_udre", o_udre, 1);
    n = 0;
    while (!o_txc && n < 30) begin tick(); n++; end
    chk("f1_txc", o_txc, 1);

    // Write during BUSY accepted, next one overruns, gap precedes the next request.
    i_txc_clr = 1'b1;
    tick();
    i_txc_clr = 1'b0;
    chk("clr_txc", o_txc, 0);
    wr(9'h011, 1'b1);
    tick();
    chk("t2_req", o_data_in_udr, 1);
    tick();
    chk("t2_busy_udre", o_udre, 1);
    wr(9'h022, 1'b1);
    chk("t2_acc_udre", o_udre, 0);
    wr(9'h033, 1'b0);
    chk("t2_ovr", o_wr_overrun, 1);
    chk("t2_data_kept", o_tx_data, 9'h022);
    tick();
    chk("t2_ovr_pulse", o_wr_overrun, 0);
    n = 0;
    while (!i_transmit_complete && n < 30) begin tick(); n++; end
    chk("t2_gap_busy", o_busy, 1);
    chk("t2_gap_req", o_data_in_udr, 0);
    chk("t2_txc_held", o_txc, 0);
    tick();
    chk("t2_idle", o_busy, 0);
    tick();
    chk("t2_req2", o_data_in_udr, 1);
    n = 0;
    while (!o_txc && n < 30) begin tick(); n++; end
    chk("t2_txc_end", o_txc, 1);

    // Write coincident with the hand-off.
    i_txc_clr = 1'b1;
    tick();
    i_txc_clr = 1'b0;
    chk("t4_clr", o_txc, 0);
    wr(9'h044, 1'b1);
    n = 0;
    while (!o_data_in_udr && n < 10) begin tick(); n++; end
    chk("t4_req", o_data_in_udr, 1);
    wr(9'h155, 1'b1);
    chk("t4_udre", o_udre, 0);
    chk("t4_data", o_tx_data, 9'h155);
    chk("t4_ovr", o_wr_overrun, 0);
    chk("t4_busy", o_busy, 1);
    n = 0;
    while (!o_data_in_udr && n < 30) begin tick(); n++; end
    chk("t4_req2", o_data_in_udr, 1);
    chk("t4_txc_f1", o_txc, 0);
    n = 0;
    while (!o_txc && n < 30) begin tick(); n++; end
    chk("t4_txc_f2", o_txc, 1);

    // TXC interrupt tracking and set-over-clear priority.
    i_txcie = 1'b1;
    #1;
    chk("t5_irq_on", o_txc_irq, 1);
    i_txcie = 1'b0;
    #1;
    chk("t5_irq_off", o_txc_irq, 0);
    i_txcie   = 1'b1;
    i_txc_clr = 1'b1;
    tick();
    i_txc_clr = 1'b0;
    chk("t5_clr", o_txc, 0);
    chk("t5_clr_irq", o_txc_irq, 0);
    wr(9'h066, 1'b1);
    n = 0;
    while (!(m_busy && m_cnt == 1) && n < 30) begin tick(); n++; end
    chk("t5_sync", m_cnt, 1);
    i_txc_clr = 1'b1;
    tick();
    i_txc_clr = 1'b0;
    chk("t5_set_wins", o_txc, 1);
    chk("t5_irq_set", o_txc_irq, 1);
    i_txc_clr = 1'b1;
    tick();
    i_txc_clr = 1'b0;
    chk("t5_later_clr", o_txc, 0);

    // Reset in BUSY discards the pending byte.
    wr(9'h077, 1'b1);
    n = 0;
    while (!(o_busy && o_udre && !o_data_in_udr) && n < 20) begin tick(); n++; end
    chk("t6_in_busy", o_busy, 1);
    wr(9'h088, 1'b0);
    chk("t6_pending", o_udre, 0);
    i_rst_n = 1'b0;
    #1;
    chk("t6_udre", o_udre, 1);
    chk("t6_txc", o_txc, 0);
    chk("t6_req", o_data_in_udr, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_ovr", o_wr_overrun, 0);
    chk("t6_data", o_tx_data, 0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    req_seen = 0;
    repeat (8) begin
      tick();
      if (o_data_in_udr) req_seen++;
    end
    chk("t6_no_req", req_seen, 0);
    chk("t6_udre_after", o_udre, 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
